hc_rd_credit_shim: RTL
======================

// Module: hc_rd_credit_shim
// PURPOSE
// - Sits on channel c0 between hc_requestor's read-request output and the MPF afu port.
// - Buffers read requests in a small FIFO and issues them only when MPF is not almost-full
//   and the outstanding-read count is below MAX_OUTSTANDING.
// - Credits are returned on each c0 read response, bounding reorder-buffer pressure in MPF.
// - Requires single-line (cl_len = 1CL) requests; each response returns exactly one credit.
// PARAMETERS
// - MAX_OUTSTANDING  64  maximum issued-but-unanswered reads; legal range 1..512
// - FIFO_DEPTH       4   request buffer entries; power of 2, >= 2
// PORTS
// - clk            in   1   single clock (pClkDiv2 domain); all logic on its rising edge
// - reset          in   1   asynchronous, active-high reset
// - up_valid       in   1   upstream read request valid
// - up_addr        in   42  upstream cache-line address (virtual; MPF VTP translates)
// - up_mdata       in   16  upstream request tag
// - up_ready       out  1   shim can accept request this cycle (= FIFO not full)
// - dn_valid       out  1   read request issued to MPF this cycle
// - dn_addr        out  42  issued address
// - dn_mdata       out  16  issued tag, unmodified
// - dn_almfull     in   1   MPF c0TxAlmFull
// - rsp_valid      in   1   c0 read response valid (c0Rx rspValid with rdRsp type)
// - outstanding    out  10  current outstanding-read count
// - issued_cnt     out  32  total requests issued since reset, wraps at 2^32
// - credit_err     out  1   sticky: response received while outstanding == 0
// BEHAVIOUR
// - Reset: FIFO emptied; dn_valid = 0; dn_addr and dn_mdata = 0; outstanding = 0;
//   issued_cnt = 0; credit_err = 0; up_ready = 1 on the first cycle after reset release.
// - Mid-operation reset: discards queued requests and resets all counters immediately
//   (asynchronous). In-flight responses arriving after reset set credit_err.
// - Accept: up_valid && up_ready pushes {addr, mdata} into the FIFO.
// - Issue condition, evaluated each cycle:
//   can_issue = !fifo_empty && !dn_almfull && (outstanding < MAX_OUTSTANDING).
// - dn_* outputs are registered. When can_issue is true, the FIFO head pops and
//   dn_valid = 1 on the next cycle with the head's addr/mdata. Otherwise dn_valid = 0.
// - dn_addr and dn_mdata hold their last values when dn_valid = 0.
// - Latency: a request accepted into an empty FIFO with credit available and almfull low
//   appears on dn_valid 2 cycles after acceptance (1 cycle FIFO write, 1 cycle output register).
// - Throughput: one issue per cycle sustained while the issue condition holds.
// - Credit counter update:
//   - outstanding += 1 on issue; outstanding -= 1 on rsp_valid.
//   - Simultaneous issue and response: outstanding is unchanged.
//   - The counter uses the pop (decision) cycle, so the MAX check is never exceeded.
// - Underflow: rsp_valid while outstanding == 0 and no issue this cycle -> outstanding stays 0,
//   credit_err set, cleared only by reset.
// - Full and empty boundaries:
//   - up_ready = 0 when the FIFO holds FIFO_DEPTH entries. A simultaneous pop does NOT
//     re-open up_ready in the same cycle (no combinational ready path).
//   - Pop of an empty FIFO never occurs.
// - dn_almfull is sampled in the same cycle as the decision. MPF tolerates the 1 extra
//   registered request after almfull rises.
// - issued_cnt increments on each issue and wraps from 32'hFFFF_FFFF to 0.
// TESTING
// - Single request, idle: up_valid for 1 cycle with addr 42'h100, mdata 16'h0005
//   -> dn_valid for 1 cycle, 2 cycles later, with the same addr/mdata;
//   outstanding = 1; issued_cnt = 1.
// - Credit limit, MAX_OUTSTANDING = 4: push 6 requests with no responses -> exactly 4 issued,
//   outstanding = 4, 2 requests held in the FIFO.
//   Then 1 rsp_valid -> 1 more issue; outstanding back to 4.
// - almfull stall: hold dn_almfull = 1 and push 4 requests -> dn_valid stays 0 and up_ready = 0
//   after the 4th push. Release almfull -> 4 back-to-back issues in original order.
// - Simultaneous events: with outstanding = 3, an issue and a rsp_valid in the same cycle
//   -> outstanding stays 3 and credit_err stays 0.
// - Underflow: rsp_valid with outstanding = 0 -> credit_err = 1 and stays 1;
//   outstanding remains 0.
// - Reset mid-operation: FIFO holds 3 entries and outstanding = 2; assert reset for 1 cycle
//   -> all outputs return to their reset values and no dn_valid occurs after release
//   without new upstream requests.

Source files
------------

// File: rtl/hc_rd_credit_shim_if.sv
// Read-request bus around the c0 credit shim: upstream request channel,
// downstream MPF request channel, MPF almost-full and c0 read-response strobe.
// Ports: up_valid/up_addr/up_mdata/up_ready upstream; dn_valid/dn_addr/dn_mdata
//        downstream; dn_almfull back-pressure; rsp_valid credit return.
interface hc_rd_credit_shim_if;
   logic        up_valid;
   logic [41:0] up_addr;
   logic [15:0] up_mdata;
   logic        up_ready;
   logic        dn_valid;
   logic [41:0] dn_addr;
   logic [15:0] dn_mdata;
   logic        dn_almfull;
   logic        rsp_valid;

   modport master (
      output up_valid, up_addr, up_mdata, dn_almfull, rsp_valid,
      input  up_ready, dn_valid, dn_addr, dn_mdata
   );

   modport slave (
      input  up_valid, up_addr, up_mdata, dn_almfull, rsp_valid,
      output up_ready, dn_valid, dn_addr, dn_mdata
   );
endinterface

// File: rtl/hc_rd_credit_shim.sv
// Credit-limited read-request shim on c0: FIFO-buffers requests, issues them
// to MPF only below MAX_OUTSTANDING and while MPF is not almost full.
// Ports: clk, reset (async, active-high); bus (slave side of the shim bus);
//        outstanding, issued_cnt, credit_err (status outputs).
module hc_rd_credit_shim #(
   parameter int MAX_OUTSTANDING = 64,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   hc_rd_credit_shim_if.slave   bus,
   output logic [9:0]           outstanding,
   output logic [31:0]          issued_cnt,
   output logic                 credit_err
);

   localparam int          AW      = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);
   localparam logic [9:0]  MAX_L   = 10'(MAX_OUTSTANDING);

   logic [57:0] mem [FIFO_DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic [AW:0] count;
   logic        fifo_empty;
   logic        fifo_full;
   logic        push;
   logic        pop;

   // Pointers carry an extra wrap bit so full and empty are distinguishable.
   assign count      = wr_ptr - rd_ptr;
   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == DEPTH_L);

   // Ready depends only on registered state: a pop never re-opens it early.
   assign bus.up_ready = !fifo_full;

   assign push = bus.up_valid && !fifo_full;
   assign pop  = !fifo_empty && !bus.dn_almfull && (outstanding < MAX_L);

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr[AW-1:0]] <= {bus.up_addr, bus.up_mdata};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         bus.dn_valid <= 1'b0;
         bus.dn_addr  <= '0;
         bus.dn_mdata <= '0;
         outstanding  <= '0;
         issued_cnt   <= '0;
         credit_err   <= 1'b0;
      end else begin
         bus.dn_valid <= pop;
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr                     <= rd_ptr + 1'b1;
            {bus.dn_addr, bus.dn_mdata} <= mem[rd_ptr[AW-1:0]];
            issued_cnt                 <= issued_cnt + 32'd1;
         end
         // Credits move at the decision cycle, so the limit is never overshot.
         unique case ({pop, bus.rsp_valid})
            2'b10: outstanding <= outstanding + 10'd1;
            2'b01: begin
               if (outstanding == '0)
                  credit_err <= 1'b1;
               else
                  outstanding <= outstanding - 10'd1;
            end
            default: ;
         endcase
      end
   end

endmodule
